// File: rtl/npu_pkg.sv
// npu_pkg: shared NPU control-plane definitions.
//   AXI_A_W / AXI_D_W / AXI_S_W : AXI4-Lite address, data and strobe widths.
//   ARB_N_REQ                   : number of requesters on the control-plane arbiter.
//   wr_arb_state_t / rd_arb_state_t : arbiter write / read path FSM states.
package npu_pkg;

  localparam int AXI_A_W   = 32;
  localparam int AXI_D_W   = 32;
  localparam int AXI_S_W   = AXI_D_W / 8;
  localparam int ARB_N_REQ = 2;

  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wr_arb_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_arb_state_t;

endpackage

// File: rtl/AXI4LITE_BUS_SV.sv
// AXI4LITE_BUS_SV: AXI4-Lite bundle (no response codes on this control plane).
//   wa_* : write address channel     wd_* : write data channel
//   wr_* : write response channel    ra_* : read address channel
//   rd_* : read data channel
//   Master modport drives requests; Slave modport drives readies and responses.
interface AXI4LITE_BUS_SV;
  import npu_pkg::*;

  logic               wa_valid;
  logic               wa_ready;
  logic [AXI_A_W-1:0] wa_addr;
  logic               wd_valid;
  logic               wd_ready;
  logic [AXI_D_W-1:0] wd_data;
  logic [AXI_S_W-1:0] wd_strb;
  logic               wr_valid;
  logic               wr_ready;
  logic               ra_valid;
  logic               ra_ready;
  logic [AXI_A_W-1:0] ra_addr;
  logic               rd_valid;
  logic               rd_ready;
  logic [AXI_D_W-1:0] rd_data;

  modport Master (
    output wa_valid, wa_addr, wd_valid, wd_data, wd_strb, wr_ready,
           ra_valid, ra_addr, rd_ready,
    input  wa_ready, wd_ready, wr_valid, ra_ready, rd_valid, rd_data
  );

  modport Slave (
    input  wa_valid, wa_addr, wd_valid, wd_data, wd_strb, wr_ready,
           ra_valid, ra_addr, rd_ready,
    output wa_ready, wd_ready, wr_valid, ra_ready, rd_valid, rd_data
  );

endinterface

// File: rtl/npu_rr_arb2.sv
// npu_rr_arb2: two-requester round-robin arbiter with a 1-bit last-granted register.
//   clk, rst   : clock, asynchronous active-high reset (last resets to 1, so M0 wins first tie)
//   req        : request vector
//   update     : pulse that records the current gnt as last granted
//   fixed_prio : 1 = requester 0 always wins a tie
//   gnt        : one-hot combinational grant
module npu_rr_arb2
  import npu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ARB_N_REQ-1:0] req,
  input  logic                 update,
  input  logic                 fixed_prio,
  output logic [ARB_N_REQ-1:0] gnt
);

  logic last;

  // A single requester always wins; on a tie the one not last granted wins.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = (fixed_prio || last) ? 2'b01 : 2'b10;
  end

  // The owner drives req with the held grant while busy, so gnt at update
  // time is the grant being retired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last <= 1'b1;
    else if (update) last <= gnt[1];
  end

endmodule

// File: rtl/npu_axi4lite_arbiter.sv
// npu_axi4lite_arbiter: two-master to one-slave AXI4-Lite arbiter (NPU control plane).
//   clk, rst : clock, asynchronous active-high reset
//   s0       : requester 0 (host), Slave side of its bundle
//   s1       : requester 1 (sequencer/debug), Slave side of its bundle
//   m        : shared downstream register-file slave, Master side
//   FIXED_PRIO : 0 = round-robin ties, 1 = s0 always wins a tie
// Handshake rule on every channel: a transfer happens on a cycle where valid
// and ready are both 1; the source holds valid and payload stable until then,
// and ready may depend combinationally on valid. The write and read paths are
// arbitrated independently, one outstanding transaction each; the grant is
// registered in IDLE and held until the response handshake. Outside the
// granted state all forwarded outputs are 0.
module npu_axi4lite_arbiter
  import npu_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0
)(
  input  logic           clk,
  input  logic           rst,
  AXI4LITE_BUS_SV.Slave  s0,
  AXI4LITE_BUS_SV.Slave  s1,
  AXI4LITE_BUS_SV.Master m
);

  localparam logic FIXED = (FIXED_PRIO != 0);

  wr_arb_state_t  w_state;
  rd_arb_state_t  r_state;
  logic [1:0]     wgnt, rgnt;
  logic           aw_done, w_done;
  logic [1:0]     w_req, r_req, w_arb_gnt, r_arb_gnt;
  logic           w_sel, r_sel;
  logic           aw_hs, w_hs, wr_hs, ra_hs, rd_hs;
  logic           w_update, r_update;

  assign w_sel = wgnt[1];
  assign r_sel = rgnt[1];

  // While busy the arbiter sees only the held grant, keeping gnt stable for update.
  assign w_req = (w_state == W_IDLE) ?
                 {s1.wa_valid | s1.wd_valid, s0.wa_valid | s0.wd_valid} : wgnt;
  assign r_req = (r_state == R_IDLE) ? {s1.ra_valid, s0.ra_valid} : rgnt;

  assign aw_hs    = m.wa_valid & m.wa_ready;
  assign w_hs     = m.wd_valid & m.wd_ready;
  assign wr_hs    = m.wr_valid & m.wr_ready;
  assign ra_hs    = m.ra_valid & m.ra_ready;
  assign rd_hs    = m.rd_valid & m.rd_ready;
  assign w_update = (w_state == W_RESP) & wr_hs;
  assign r_update = (r_state == R_DATA) & rd_hs;

  npu_rr_arb2 u_wr_arb (
    .clk(clk), .rst(rst), .req(w_req), .update(w_update),
    .fixed_prio(FIXED), .gnt(w_arb_gnt)
  );

  npu_rr_arb2 u_rd_arb (
    .clk(clk), .rst(rst), .req(r_req), .update(r_update),
    .fixed_prio(FIXED), .gnt(r_arb_gnt)
  );

  // Write path FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      wgnt    <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (|w_req) begin
          wgnt    <= w_arb_gnt;
          w_state <= W_XFER;
        end
        W_XFER: begin
          // AW and W complete in either order or together; flags remember which.
          if ((aw_done | aw_hs) && (w_done | w_hs)) begin
            w_state <= W_RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        W_RESP: if (wr_hs) begin
          w_state <= W_IDLE;
          wgnt    <= '0;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read path FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      rgnt    <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (|r_req) begin
          rgnt    <= r_arb_gnt;
          r_state <= R_ADDR;
        end
        R_ADDR: if (ra_hs) r_state <= R_DATA;
        R_DATA: if (rd_hs) begin
          r_state <= R_IDLE;
          rgnt    <= '0;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Combinational routing for the granted master; everything else stays 0.
  always_comb begin
    m.wa_valid  = 1'b0;  m.wa_addr = '0;
    m.wd_valid  = 1'b0;  m.wd_data = '0;  m.wd_strb = '0;
    m.wr_ready  = 1'b0;
    m.ra_valid  = 1'b0;  m.ra_addr = '0;
    m.rd_ready  = 1'b0;
    s0.wa_ready = 1'b0;  s0.wd_ready = 1'b0;  s0.wr_valid = 1'b0;
    s0.ra_ready = 1'b0;  s0.rd_valid = 1'b0;  s0.rd_data  = '0;
    s1.wa_ready = 1'b0;  s1.wd_ready = 1'b0;  s1.wr_valid = 1'b0;
    s1.ra_ready = 1'b0;  s1.rd_valid = 1'b0;  s1.rd_data  = '0;

    if (w_state == W_XFER) begin
      // A completed channel is masked so it is issued exactly once.
      m.wa_valid = (w_sel ? s1.wa_valid : s0.wa_valid) & ~aw_done;
      m.wa_addr  =  w_sel ? s1.wa_addr  : s0.wa_addr;
      m.wd_valid = (w_sel ? s1.wd_valid : s0.wd_valid) & ~w_done;
      m.wd_data  =  w_sel ? s1.wd_data  : s0.wd_data;
      m.wd_strb  =  w_sel ? s1.wd_strb  : s0.wd_strb;
      if (w_sel) begin
        s1.wa_ready = m.wa_ready & ~aw_done;
        s1.wd_ready = m.wd_ready & ~w_done;
      end else begin
        s0.wa_ready = m.wa_ready & ~aw_done;
        s0.wd_ready = m.wd_ready & ~w_done;
      end
    end

    if (w_state == W_RESP) begin
      m.wr_ready = w_sel ? s1.wr_ready : s0.wr_ready;
      if (w_sel) s1.wr_valid = m.wr_valid;
      else       s0.wr_valid = m.wr_valid;
    end

    if (r_state == R_ADDR) begin
      m.ra_valid = r_sel ? s1.ra_valid : s0.ra_valid;
      m.ra_addr  = r_sel ? s1.ra_addr  : s0.ra_addr;
      if (r_sel) s1.ra_ready = m.ra_ready;
      else       s0.ra_ready = m.ra_ready;
    end

    if (r_state == R_DATA) begin
      m.rd_ready = r_sel ? s1.rd_ready : s0.rd_ready;
      if (r_sel) begin
        s1.rd_valid = m.rd_valid;
        s1.rd_data  = m.rd_data;
      end else begin
        s0.rd_valid = m.rd_valid;
        s0.rd_data  = m.rd_data;
      end
    end
  end

endmodule
